// File: rtl/dsp_equation_vector_mac.sv
// Vector multiply / multiply-accumulate equation engine streaming operands through the file subsystem.
// Optional clamping of scaled products and accumulator: define DSP_EQUATION_SATURATE_EN.
module dsp_equation_vector_mac #(
    parameter int DW    = 32,
    parameter int ACC_W = 72,
    parameter int LEN_W = 16
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          equation_enable,
    input  logic [DW-1:0] dsp_input0_reg,
    input  logic [DW-1:0] dsp_input1_reg,
    input  logic [DW-1:0] dsp_input2_reg,
    input  logic [DW-1:0] dsp_input3_reg,
    output logic [7:0]    file_num,
    output logic          file_read,
    output logic          file_write,
    output logic [DW-1:0] file_write_data,
    input  logic [DW-1:0] file_read_data,
    input  logic          file_active,
    input  logic [31:0]   rd_ptr,
    input  logic [31:0]   wr_ptr,
    output logic          equation_done,
    output logic          interrupt,
    output logic          error,
    output logic [DW-1:0] dsp_output0_reg,
    output logic [DW-1:0] dsp_output1_reg,
    output logic [DW-1:0] dsp_output2_reg,
    output logic [DW-1:0] dsp_output3_reg
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD0      = 4'd1,
        S_RD0_DONE = 4'd2,
        S_RD1      = 4'd3,
        S_RD1_DONE = 4'd4,
        S_MULT     = 4'd5,
        S_WR       = 4'd6,
        S_WR_DONE  = 4'd7,
        S_FINISH   = 4'd8
    } state_t;

    logic             ctl_start, ctl_signed, ctl_mac, ctl_scalar, ctl_clear;
    logic [7:0]       in_file0, in_file1, out_file;
    logic [5:0]       shift_amt;
    logic [LEN_W-1:0] vec_len;
    logic             unused_bits;

    assign ctl_start   = dsp_input0_reg[0];
    assign ctl_signed  = dsp_input0_reg[1];
    assign ctl_mac     = dsp_input0_reg[2];
    assign ctl_scalar  = dsp_input0_reg[3];
    assign ctl_clear   = dsp_input0_reg[4];
    assign in_file0    = dsp_input1_reg[7:0];
    assign in_file1    = dsp_input1_reg[15:8];
    assign out_file    = dsp_input3_reg[7:0];
    assign shift_amt   = dsp_input3_reg[13:8];
    assign vec_len     = dsp_input3_reg[16+LEN_W-1:16];
    assign unused_bits = ^{dsp_input0_reg[DW-1:5], dsp_input1_reg[DW-1:16], dsp_input3_reg[15:14]};

    state_t            state_q, state_d;
    logic [DW-1:0]     op0_q, op0_d, op1_q, op1_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DW-1:0]     scaled_q, scaled_d;
    logic [DW-1:0]     sample_count_q, sample_count_d;
    logic              last_q, last_d;
    logic              error_q, error_d;
    logic              done_q, done_d;
    logic [DW-1:0]     out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;

    // Datapath for the MULT cycle
    logic [2*DW-1:0]        prod_u, prod, shr;
    logic signed [2*DW-1:0] prod_s, shr_s;
    logic [ACC_W-1:0]       prod_ext, acc_next;
    logic [ACC_W:0]         acc_sum;
    logic [DW-1:0]          scaled_val;
    logic                   scale_ovf, acc_ovf;

    always_comb begin
        prod_u = {{DW{1'b0}}, op0_q} * {{DW{1'b0}}, op1_q};
        prod_s = $signed({{DW{op0_q[DW-1]}}, op0_q}) * $signed({{DW{op1_q[DW-1]}}, op1_q});
        prod   = ctl_signed ? prod_s : prod_u;
        shr_s  = prod_s >>> shift_amt;
        shr    = ctl_signed ? shr_s : (prod_u >> shift_amt);
        // The scaled value fits when every bit above the kept field matches its sign (signed) or is zero.
        scale_ovf = ctl_signed ? !((&shr[2*DW-1:DW-1]) || !(|shr[2*DW-1:DW-1]))
                               : (|shr[2*DW-1:DW]);
        prod_ext  = ctl_signed ? ACC_W'($signed(prod)) : ACC_W'(prod);
        acc_sum   = {1'b0, acc_q} + {1'b0, prod_ext};
        acc_ovf   = ctl_signed ? ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                                  (acc_sum[ACC_W-1] != acc_q[ACC_W-1]))
                               : acc_sum[ACC_W];
`ifdef DSP_EQUATION_SATURATE_EN
        if (scale_ovf) begin
            if (ctl_signed) begin
                scaled_val = shr[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end else begin
                scaled_val = {DW{1'b1}};
            end
        end else begin
            scaled_val = shr[DW-1:0];
        end
        if (acc_ovf) begin
            if (ctl_signed) begin
                acc_next = prod_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_next = {ACC_W{1'b1}};
            end
        end else begin
            acc_next = acc_sum[ACC_W-1:0];
        end
`else
        scaled_val = shr[DW-1:0];
        acc_next   = acc_sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d         = state_q;
        op0_d           = op0_q;
        op1_d           = op1_q;
        acc_d           = acc_q;
        scaled_d        = scaled_q;
        sample_count_d  = sample_count_q;
        last_d          = last_q;
        error_d         = error_q;
        done_d          = done_q;
        out0_d          = out0_q;
        out1_d          = out1_q;
        out2_d          = out2_q;
        out3_d          = out3_q;
        file_num        = in_file0;
        file_read       = 1'b0;
        file_write      = 1'b0;
        file_write_data = '0;
        interrupt       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctl_start && equation_enable) begin
                    sample_count_d = '0;
                    error_d        = 1'b0;
                    done_d         = 1'b0;
                    out0_d         = '0;
                    out3_d         = '0;
                    if (ctl_clear) acc_d = '0;
                    state_d = S_RD0;
                end
            end
            S_RD0: begin
                file_read = 1'b1;
                if (file_active) state_d = S_RD0_DONE;
            end
            S_RD0_DONE: begin
                if (file_active) begin
                    op0_d = file_read_data;
                end else if (ctl_scalar) begin
                    op1_d   = dsp_input2_reg;
                    state_d = S_MULT;
                end else begin
                    state_d = S_RD1;
                end
            end
            S_RD1: begin
                file_num  = in_file1;
                file_read = 1'b1;
                if (file_active) state_d = S_RD1_DONE;
            end
            S_RD1_DONE: begin
                file_num = in_file1;
                if (file_active) op1_d = file_read_data;
                else             state_d = S_MULT;
            end
            S_MULT: begin
                if (ctl_mac) acc_d = acc_next;
                error_d        = error_q | scale_ovf | (ctl_mac & acc_ovf);
                scaled_d       = scaled_val;
                sample_count_d = sample_count_q + 1'b1;
                last_d         = (vec_len != '0)
                               ? ((sample_count_q + 1'b1) == DW'(vec_len))
                               : (rd_ptr == wr_ptr);
                state_d        = S_WR;
            end
            S_WR: begin
                file_num        = out_file;
                file_write      = 1'b1;
                file_write_data = scaled_q;
                out0_d          = scaled_q;
                out3_d          = sample_count_q;
                if (ctl_mac) begin
                    out1_d = acc_q[DW-1:0];
                    out2_d = acc_q[2*DW-1:DW];
                end
                if (file_active) state_d = S_WR_DONE;
            end
            S_WR_DONE: begin
                file_num = out_file;
                if (!file_active) state_d = last_q ? S_FINISH : S_RD0;
            end
            S_FINISH: begin
                interrupt = 1'b1;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q        <= S_IDLE;
            op0_q          <= '0;
            op1_q          <= '0;
            acc_q          <= '0;
            scaled_q       <= '0;
            sample_count_q <= '0;
            last_q         <= 1'b0;
            error_q        <= 1'b0;
            done_q         <= 1'b0;
            out0_q         <= '0;
            out1_q         <= '0;
            out2_q         <= '0;
            out3_q         <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q        <= state_d;
            op0_q          <= op0_d;
            op1_q          <= op1_d;
            acc_q          <= acc_d;
            scaled_q       <= scaled_d;
            sample_count_q <= sample_count_d;
            last_q         <= last_d;
            error_q        <= error_d;
            done_q         <= done_d;
            out0_q         <= out0_d;
            out1_q         <= out1_d;
            out2_q         <= out2_d;
            out3_q         <= out3_d;
        end
    end

    assign equation_done   = done_q | (state_q == S_FINISH);
    assign error           = error_q;
    assign dsp_output0_reg = out0_q;
    assign dsp_output1_reg = out1_q;
    assign dsp_output2_reg = out2_q;
    assign dsp_output3_reg = out3_q;

endmodule
